sec_violation_ctrl: RTL and testbench

SEC_VIOLATION_CTRL -- requirements
Module: sec_violation_ctrl

---
 rtl/sec_violation_ctrl.sv | 137 +++++++++++++
 tb/tb_sec_violation_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sec_violation_ctrl.sv
// Security violation controller: qualifies per-source violation pulses, logs and
// counts them, and raises a redirect request with REQ/HOLD handshaking to the frontend.
module sec_violation_ctrl #(
  parameter int unsigned NUM_SRC     = 4,
  parameter logic [31:0] CRASH_ADDR  = 32'h0000_0000,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_SRC-1:0]         viol_i,
  input  logic                       valid_i,
  input  logic [31:0]                pc_i,
  input  logic                       en_crash_i,
  input  logic                       clr_i,
  input  logic                       flush_ack_i,
  output logic                       crash_req_o,
  output logic [31:0]                crash_target_o,
  output logic [$clog2(NUM_SRC)-1:0] cause_o,
  output logic [31:0]                cause_pc_o,
  output logic [NUM_SRC-1:0]         viol_log_o,
  output logic [7:0]                 viol_cnt_o,
  output logic                       busy_o
);

  localparam int unsigned CAW = $clog2(NUM_SRC);
  // Keep the hold counter at least one bit wide so HOLD_CYCLES=0 still elaborates.
  localparam int unsigned HCW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               crash_req_q, crash_req_d;
  logic [CAW-1:0]     cause_q, cause_d;
  logic [31:0]        cause_pc_q, cause_pc_d;
  logic [NUM_SRC-1:0] viol_log_q, viol_log_d;
  logic [7:0]         viol_cnt_q, viol_cnt_d;
  logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;

  logic [NUM_SRC-1:0] qual;
  logic               any_qual;
  logic [CAW-1:0]     first_idx;
  logic               found;

  always_comb begin
    qual      = viol_i & {NUM_SRC{valid_i}};
    any_qual  = |qual;
    first_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (qual[i] && !found) begin
        first_idx = CAW'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cause_pc_d = cause_pc_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (any_qual && en_crash_i) begin
          state_d    = S_REQ;
          cause_d    = first_idx;
          cause_pc_d = pc_i;
        end
      end
      S_REQ: begin
        if (flush_ack_i) begin
          if (HOLD_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_HOLD;
            hold_cnt_d = HCW'(HOLD_CYCLES);
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q <= HCW'(1)) begin
          state_d    = S_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HCW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        hold_cnt_d = '0;
      end
    endcase

    // Request flop tracks the next state so crash_req_o is a pure register output.
    crash_req_d = (state_d == S_REQ);

    if (clr_i) begin
      viol_log_d = '0;
      viol_cnt_d = '0;
    end else begin
      viol_log_d = viol_log_q | qual;
      viol_cnt_d = (any_qual && (viol_cnt_q != 8'hFF)) ? viol_cnt_q + 8'd1 : viol_cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      crash_req_q <= 1'b0;
      cause_q     <= '0;
      cause_pc_q  <= '0;
      viol_log_q  <= '0;
      viol_cnt_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      crash_req_q <= crash_req_d;
      cause_q     <= cause_d;
      cause_pc_q  <= cause_pc_d;
      viol_log_q  <= viol_log_d;
      viol_cnt_q  <= viol_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign crash_req_o    = crash_req_q;
  assign crash_target_o = CRASH_ADDR;
  assign cause_o        = cause_q;
  assign cause_pc_o     = cause_pc_q;
  assign viol_log_o     = viol_log_q;
  assign viol_cnt_o     = viol_cnt_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sec_violation_ctrl.sv
// Directed bench for sec_violation_ctrl: redirect handshake, logging, saturation,
// valid gating, clear priority and asynchronous reset.
module tb_sec_violation_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  viol;
  logic        valid;
  logic [31:0] pc;
  logic        en_crash;
  logic        clr;
  logic        flush_ack;
  logic        crash_req;
  logic [31:0] crash_target;
  logic [1:0]  cause;
  logic [31:0] cause_pc;
  logic [3:0]  viol_log;
  logic [7:0]  viol_cnt;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sec_violation_ctrl #(
    .NUM_SRC    (4),
    .CRASH_ADDR (32'h0000_0000),
    .HOLD_CYCLES(2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .viol_i        (viol),
    .valid_i       (valid),
    .pc_i          (pc),
    .en_crash_i    (en_crash),
    .clr_i         (clr),
    .flush_ack_i   (flush_ack),
    .crash_req_o   (crash_req),
    .crash_target_o(crash_target),
    .cause_o       (cause),
    .cause_pc_o    (cause_pc),
    .viol_log_o    (viol_log),
    .viol_cnt_o    (viol_cnt),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, crash_req}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_cause"}, {30'd0, cause},     32'd0);
    check({tag, "_pc"},    cause_pc,           32'd0);
    check({tag, "_log"},   {28'd0, viol_log},  32'd0);
    check({tag, "_cnt"},   {24'd0, viol_cnt},  32'd0);
  endtask

  initial begin
    logic saw_req;
    rst_n = 1'b1; viol = '0; valid = 1'b0; pc = '0; en_crash = 1'b0;
    clr = 1'b0; flush_ack = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst");
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic redirect on source 3
    en_crash = 1'b1; viol = 4'b1000; valid = 1'b1; pc = 32'h8000_0100;
    step();
    viol = '0; valid = 1'b0; pc = 32'h1111_1111;
    check("t1_req",    {31'd0, crash_req}, 32'd1);
    check("t1_cause",  {30'd0, cause},     32'd3);
    check("t1_pc",     cause_pc,           32'h8000_0100);
    check("t1_target", crash_target,       32'h0000_0000);
    check("t1_busy",   {31'd0, busy},      32'd1);
    check("t1_cnt",    {24'd0, viol_cnt},  32'd1);
    check("t1_log",    {28'd0, viol_log},  32'h8);
    en_crash = 1'b0;  // dropping enable must not abort the sequence
    step();
    check("t1_req2",   {31'd0, crash_req}, 32'd1);
    step();
    check("t1_req3",   {31'd0, crash_req}, 32'd1);
    check("t1_stable", cause_pc,           32'h8000_0100);
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    check("t1_hold1_req",  {31'd0, crash_req}, 32'd0);
    check("t1_hold1_busy", {31'd0, busy},      32'd1);
    step();
    check("t1_hold2_busy", {31'd0, busy},      32'd1);
    step();
    check("t1_idle_busy",  {31'd0, busy},      32'd0);

    // Clear does not touch the cause registers; ack in IDLE is ignored
    clr = 1'b1; flush_ack = 1'b1;
    step();
    clr = 1'b0; flush_ack = 1'b0;
    check("clr_cnt",   {24'd0, viol_cnt}, 32'd0);
    check("clr_log",   {28'd0, viol_log}, 32'd0);
    check("clr_cause", {30'd0, cause},    32'd3);
    check("ack_idle",  {31'd0, busy},     32'd0);

    // Simultaneous sources, lowest index wins
    en_crash = 1'b1; viol = 4'b0110; valid = 1'b1; pc = 32'h0000_1234;
    step();
    viol = '0; valid = 1'b0;
    check("t2_req",   {31'd0, crash_req}, 32'd1);
    check("t2_cause", {30'd0, cause},     32'd1);
    check("t2_log",   {28'd0, viol_log},  32'h6);
    check("t2_cnt",   {24'd0, viol_cnt},  32'd1);
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    // Violation in first HOLD cycle
    viol = 4'b0001; valid = 1'b1; pc = 32'hDEAD_BEEF;
    step();
    viol = '0; valid = 1'b0;
    check("t3_cnt",   {24'd0, viol_cnt},  32'd2);
    check("t3_log",   {28'd0, viol_log},  32'h7);
    check("t3_cause", {30'd0, cause},     32'd1);
    check("t3_pc",    cause_pc,           32'h0000_1234);
    check("t3_req",   {31'd0, crash_req}, 32'd0);
    check("t3_busy",  {31'd0, busy},      32'd1);
    step();
    check("t3_idle",  {31'd0, busy},      32'd0);
    step();
    check("t3_noreq", {31'd0, crash_req}, 32'd0);
    check("t3_nobusy",{31'd0, busy},      32'd0);

    // Valid gating
    clr = 1'b1;
    step();
    clr = 1'b0; viol = 4'b1111; valid = 1'b0;
    step();
    viol = '0;
    check("vg_busy", {31'd0, busy},     32'd0);
    check("vg_log",  {28'd0, viol_log}, 32'd0);
    check("vg_cnt",  {24'd0, viol_cnt}, 32'd0);

    // Log-only mode with counter saturation
    en_crash = 1'b0; viol = 4'b0001; valid = 1'b1; saw_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (crash_req) saw_req = 1'b1;
    end
    check("lo_noreq", {31'd0, saw_req},  32'd0);
    check("lo_cnt",   {24'd0, viol_cnt}, 32'h0000_00FF);
    check("lo_log",   {28'd0, viol_log}, 32'h1);
    // Clear wins over a simultaneous violation
    clr = 1'b1;
    step();
    clr = 1'b0; viol = '0; valid = 1'b0;
    check("cp_cnt", {24'd0, viol_cnt}, 32'd0);
    check("cp_log", {28'd0, viol_log}, 32'd0);

    // Reset between clock edges while in REQ
    en_crash = 1'b1; viol = 4'b0100; valid = 1'b1; pc = 32'h4000_0000;
    step();
    viol = '0; valid = 1'b0;
    check("rm_req",   {31'd0, crash_req}, 32'd1);
    check("rm_cause", {30'd0, cause},     32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rm_async");
    step();
    rst_n = 1'b1;
    viol = 4'b0010; valid = 1'b1; pc = 32'h4000_0010;
    step();
    viol = '0; valid = 1'b0;
    check("pr_req",   {31'd0, crash_req}, 32'd1);
    check("pr_cause", {30'd0, cause},     32'd1);
    check("pr_pc",    cause_pc,           32'h4000_0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
